bp_me_cache_dma_responder: RTL and testbench
============================================

// Module: bp_me_cache_dma_responder
// PURPOSE
// - DRAM-side responder for the cache slice's DMA port: accepts bedrock dram mem_cmd header + dword data stream, returns mem_resp header + data stream.
// - Backs requests with an internal dword-wide sync-read store; used as the simulation memory behind bp_me_cache_slice.
// PARAMETERS
// - bp_params_p  e_bp_default_cfg  proc config; supplies paddr_width_p, dword_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p
// - mem_els_p    4096              store depth in dwords; word index = addr[3+:lg(mem_els_p)]
// PORTS
// - clk_i                    in   1   clock
// - reset_i                  in   1   asynchronous, active-high reset
// - mem_cmd_header_i         in   bp_bedrock_dram_mem_msg_header_width_lp  command header (msg_type, size, addr, payload)
// - mem_cmd_header_v_i       in   1   header valid
// - mem_cmd_header_yumi_o    out  1   header consumed
// - mem_cmd_data_i           in   dword_width_p  write data beat
// - mem_cmd_data_v_i         in   1   write beat valid
// - mem_cmd_data_yumi_o      out  1   write beat consumed
// - mem_resp_header_o        out  bp_bedrock_dram_mem_msg_header_width_lp  response header
// - mem_resp_header_v_o      out  1   response header valid
// - mem_resp_header_ready_i  in   1   sink ready (valid-ready)
// - mem_resp_data_o          out  dword_width_p  read data beat
// - mem_resp_data_v_o        out  1   read beat valid
// - mem_resp_data_ready_i    in   1   sink ready (valid-ready)
// BEHAVIOUR
// - Reset (async): state=e_ready, beat cnt=0, rd_valid_r=0; all v/yumi outputs 0; store contents not reset.
// - Beats: n = (size<e_bedrock_msg_size_8) ? 1 : (1<<size)/8, max 16 (128 B); base word = addr word index with low lg(n) bits cleared; beat k -> base+k, wraps mod mem_els_p.
// - e_ready: header_yumi_o=header_v_i; latch header, cnt=0. wr -> e_wr_data; rd -> e_rd_hdr; other msg_type -> e_wr_resp (no store access).
//   Data beats presented in e_ready are not consumed (data_yumi_o=0).
// - e_wr_data: data_yumi_o=data_v_i; on yumi write beat cnt, cnt++; on beat n-1 -> e_wr_resp.
// - e_wr_resp: resp_header_v_o=1; on ready_i -> e_ready. Consecutive back-to-back cmds: next header accepted the cycle after.
// - e_rd_hdr: resp_header_v_o=1; on ready_i issue sync read of beat 0, cnt=0 -> e_rd_data.
// - e_rd_data: data_v_o=rd_valid_r (set cycle after a read issue). On v&ready: cnt==n-1 -> e_ready, rd_valid_r=0; else issue read cnt+1 same cycle.
//   data_o held stable while v&~ready (store read only on issue).
// - Latency, ready tied high: rd header accept c0, resp header c1, data beats c2..c(n+1); wr resp header 1 cycle after last beat.
// - Response header = latched cmd header verbatim (msg_type, size, addr, payload).
// - Header and data handshakes never overlap; at most one command in flight.
// - Reset asserted mid-transfer aborts it immediately; partially written beats remain in store.
// STRUCTURE
// - bp_me_pkg: enum bp_me_dma_resp_state_e {e_ready, e_wr_data, e_wr_resp, e_rd_hdr, e_rd_data}.
// - Storage: one bsg_mem_1rw_sync instance (width dword_width_p, els mem_els_p); write has priority-free use since FSM never reads and writes same cycle.
// - Counter: 4-bit beat cnt; header latch via bsg_dff_reset_en.
// TESTING
// - Write 64 B at 0x8000_0040, beats 0x11..0x88, ready high -> 8 data yumis, one wr resp header addr 0x8000_0040, size e_bedrock_msg_size_64.
// - Read 64 B at 0x8000_0040 after above -> resp header c1, data 0x11..0x88 on c2..c9.
// - Read with data_ready_i toggled 1,0,0,1 -> each beat held stable while ready low; no beat dropped or duplicated.
// - Write header with data_v_i delayed 3 cycles and gaps between beats -> no yumi without valid; resp only after 8th beat.
// - Address 0x1_FFF8 with mem_els_p=4096, size 8 B -> index wraps to 4095; read returns written value.
// - reset_i pulsed during e_rd_data beat 3 -> all v outputs 0 same cycle; next read completes normally.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types for the bedrock DRAM-side DMA responder.
// Header layout, message enums, responder FSM states and beat-count helper.
package bp_me_pkg;

    localparam int paddr_width_p  = 40;
    localparam int dword_width_p  = 64;
    localparam int lce_id_width_p = 4;
    localparam int lce_assoc_p    = 8;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]      lce_id;
        logic [$clog2(lce_assoc_p)-1:0] way_id;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s  payload;
        bp_bedrock_msg_size_e     size;
        logic [paddr_width_p-1:0] addr;
        bp_bedrock_mem_type_e     msg_type;
    } bp_bedrock_mem_header_s;

    localparam int bp_bedrock_dram_mem_msg_header_width_lp =
        $bits(bp_bedrock_mem_header_s);

    typedef enum logic [2:0] {
        e_ready,
        e_wr_data,
        e_wr_resp,
        e_rd_hdr,
        e_rd_data
    } bp_me_dma_resp_state_e;

    // Index of the last dword beat; sub-dword sizes still move one beat.
    function automatic logic [3:0] beats_m1(bp_bedrock_msg_size_e size);
        case (size)
            e_bedrock_msg_size_16:  return 4'd1;
            e_bedrock_msg_size_32:  return 4'd3;
            e_bedrock_msg_size_64:  return 4'd7;
            e_bedrock_msg_size_128: return 4'd15;
            default:                return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bp_me_cache_dma_responder_mem.sv
// Single-port synchronous-read dword store backing the DMA responder.
// Read data is registered and holds until the next read access.
module bp_me_cache_dma_responder_mem #(
    parameter int width_p = 64,
    parameter int els_p   = 4096,
    localparam int lg_els_lp = $clog2(els_p)
)(
    input  logic                 clk_i,
    input  logic                 v_i,
    input  logic                 w_i,
    input  logic [lg_els_lp-1:0] addr_i,
    input  logic [width_p-1:0]   data_i,
    output logic [width_p-1:0]   data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (v_i & w_i)
            mem[addr_i] <= data_i;
        else if (v_i)
            data_o <= mem[addr_i];
    end

endmodule

// File: rtl/bp_me_cache_dma_responder.sv
// DRAM-side responder for the cache slice DMA port: bedrock mem_cmd in,
// mem_resp out, backed by an internal dword store.
module bp_me_cache_dma_responder
    import bp_me_pkg::*;
#(
    parameter int mem_els_p = 4096
)(
    input  logic                                               clk_i,
    input  logic                                               reset_i,
    input  logic [bp_bedrock_dram_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
    input  logic                                               mem_cmd_header_v_i,
    output logic                                               mem_cmd_header_yumi_o,
    input  logic [dword_width_p-1:0]                           mem_cmd_data_i,
    input  logic                                               mem_cmd_data_v_i,
    output logic                                               mem_cmd_data_yumi_o,
    output logic [bp_bedrock_dram_mem_msg_header_width_lp-1:0] mem_resp_header_o,
    output logic                                               mem_resp_header_v_o,
    input  logic                                               mem_resp_header_ready_i,
    output logic [dword_width_p-1:0]                           mem_resp_data_o,
    output logic                                               mem_resp_data_v_o,
    input  logic                                               mem_resp_data_ready_i
);

    localparam int lg_els_lp = $clog2(mem_els_p);

    bp_me_dma_resp_state_e  state_r;
    bp_bedrock_mem_header_s hdr_r;
    bp_bedrock_mem_header_s cmd_hdr;
    logic [3:0]             cnt_r;
    logic                   rd_valid_r;

    logic                 cmd_is_wr, cmd_is_rd;
    logic [3:0]           last_cnt, mem_cnt;
    logic                 is_last, data_fire, rd_issue;
    logic                 mem_v;
    logic [lg_els_lp-1:0] word_idx, base_idx, mem_addr;

    assign cmd_hdr   = mem_cmd_header_i;
    assign cmd_is_wr = cmd_hdr.msg_type inside {e_bedrock_mem_wr, e_bedrock_mem_uc_wr};
    assign cmd_is_rd = cmd_hdr.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_uc_rd};

    assign last_cnt = beats_m1(hdr_r.size);
    assign is_last  = (cnt_r == last_cnt);

    // Block-aligned base word; beats index upward from it and wrap naturally.
    assign word_idx = hdr_r.addr[3+:lg_els_lp];
    assign base_idx = word_idx & ~{{(lg_els_lp-4){1'b0}}, last_cnt};
    assign mem_cnt  = (state_r == e_rd_data) ? cnt_r + 4'd1 : cnt_r;
    assign mem_addr = base_idx + {{(lg_els_lp-4){1'b0}}, mem_cnt};

    assign mem_cmd_header_yumi_o = ~reset_i & (state_r == e_ready) & mem_cmd_header_v_i;
    assign mem_cmd_data_yumi_o   = ~reset_i & (state_r == e_wr_data) & mem_cmd_data_v_i;
    assign mem_resp_header_o     = hdr_r;
    assign mem_resp_header_v_o   = state_r inside {e_wr_resp, e_rd_hdr};
    assign mem_resp_data_v_o     = (state_r == e_rd_data) & rd_valid_r;

    assign data_fire = mem_resp_data_v_o & mem_resp_data_ready_i;
    assign rd_issue  = ((state_r == e_rd_hdr) & mem_resp_header_ready_i)
                     | (data_fire & ~is_last);
    assign mem_v     = mem_cmd_data_yumi_o | rd_issue;

    bp_me_cache_dma_responder_mem #(
        .width_p (dword_width_p),
        .els_p   (mem_els_p)
    ) store (
        .clk_i  (clk_i),
        .v_i    (mem_v),
        .w_i    (mem_cmd_data_yumi_o),
        .addr_i (mem_addr),
        .data_i (mem_cmd_data_i),
        .data_o (mem_resp_data_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= e_ready;
            hdr_r      <= '0;
            cnt_r      <= 4'd0;
            rd_valid_r <= 1'b0;
        end else begin
            unique case (state_r)
                e_ready: if (mem_cmd_header_v_i) begin
                    hdr_r <= cmd_hdr;
                    cnt_r <= 4'd0;
                    unique case (1'b1)
                        cmd_is_wr: state_r <= e_wr_data;
                        cmd_is_rd: state_r <= e_rd_hdr;
                        default:   state_r <= e_wr_resp;
                    endcase
                end
                e_wr_data: if (mem_cmd_data_yumi_o) begin
                    cnt_r <= cnt_r + 4'd1;
                    if (is_last)
                        state_r <= e_wr_resp;
                end
                e_wr_resp: if (mem_resp_header_ready_i)
                    state_r <= e_ready;
                e_rd_hdr: if (mem_resp_header_ready_i) begin
                    cnt_r      <= 4'd0;
                    rd_valid_r <= 1'b1;
                    state_r    <= e_rd_data;
                end
                e_rd_data: if (data_fire) begin
                    if (is_last) begin
                        rd_valid_r <= 1'b0;
                        state_r    <= e_ready;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_cache_dma_responder.sv
// Directed bench for the DMA responder: write/read bursts, backpressure,
// gapped write data, index wrap, other msg types and mid-transfer reset.
module tb_bp_me_cache_dma_responder;
    import bp_me_pkg::*;

    localparam int HW = bp_bedrock_dram_mem_msg_header_width_lp;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [HW-1:0] mem_cmd_header_i;
    logic          mem_cmd_header_v_i;
    logic          mem_cmd_header_yumi_o;
    logic [63:0]   mem_cmd_data_i;
    logic          mem_cmd_data_v_i;
    logic          mem_cmd_data_yumi_o;
    logic [HW-1:0] mem_resp_header_o;
    logic          mem_resp_header_v_o;
    logic          mem_resp_header_ready_i;
    logic [63:0]   mem_resp_data_o;
    logic          mem_resp_data_v_o;
    logic          mem_resp_data_ready_i;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    bp_me_cache_dma_responder #(.mem_els_p(4096)) dut (
        .clk_i                   (clk_i),
        .reset_i                 (reset_i),
        .mem_cmd_header_i        (mem_cmd_header_i),
        .mem_cmd_header_v_i      (mem_cmd_header_v_i),
        .mem_cmd_header_yumi_o   (mem_cmd_header_yumi_o),
        .mem_cmd_data_i          (mem_cmd_data_i),
        .mem_cmd_data_v_i        (mem_cmd_data_v_i),
        .mem_cmd_data_yumi_o     (mem_cmd_data_yumi_o),
        .mem_resp_header_o       (mem_resp_header_o),
        .mem_resp_header_v_o     (mem_resp_header_v_o),
        .mem_resp_header_ready_i (mem_resp_header_ready_i),
        .mem_resp_data_o         (mem_resp_data_o),
        .mem_resp_data_v_o       (mem_resp_data_v_o),
        .mem_resp_data_ready_i   (mem_resp_data_ready_i)
    );

    function automatic logic [HW-1:0] mk_hdr(bp_bedrock_mem_type_e t,
                                             bp_bedrock_msg_size_e s,
                                             logic [39:0] a);
        bp_bedrock_mem_header_s h;
        h.msg_type       = t;
        h.size           = s;
        h.addr           = a;
        h.payload.lce_id = 4'h5;
        h.payload.way_id = 3'h3;
        return h;
    endfunction

    task automatic test_reset();
        reset_i            = 1'b1;
        mem_cmd_header_i   = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h0);
        mem_cmd_header_v_i = 1'b1;
        mem_cmd_data_i     = 64'h0;
        mem_cmd_data_v_i   = 1'b1;
        mem_resp_header_ready_i = 1'b1;
        mem_resp_data_ready_i   = 1'b1;
        @(negedge clk_i); @(negedge clk_i); #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b0)
            $display("FAIL rst_hdr_yumi got=%b exp=0", mem_cmd_header_yumi_o);
        else passed++;
        checks++;
        if (mem_cmd_data_yumi_o !== 1'b0)
            $display("FAIL rst_data_yumi got=%b exp=0", mem_cmd_data_yumi_o);
        else passed++;
        checks++;
        if (mem_resp_header_v_o !== 1'b0)
            $display("FAIL rst_resp_hdr_v got=%b exp=0", mem_resp_header_v_o);
        else passed++;
        checks++;
        if (mem_resp_data_v_o !== 1'b0)
            $display("FAIL rst_resp_data_v got=%b exp=0", mem_resp_data_v_o);
        else passed++;
        @(negedge clk_i);
        reset_i            = 1'b0;
        mem_cmd_header_v_i = 1'b0;
        mem_cmd_data_v_i   = 1'b0;
    endtask

    task automatic test_write64();
        logic [HW-1:0] exp_h;
        exp_h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80_0000_40);
        @(negedge clk_i);
        mem_cmd_header_i   = exp_h;
        mem_cmd_header_v_i = 1'b1;
        mem_cmd_data_i     = 64'h11;
        mem_cmd_data_v_i   = 1'b1;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1)
            $display("FAIL wr_hdr_yumi got=%b exp=1", mem_cmd_header_yumi_o);
        else passed++;
        checks++;
        if (mem_cmd_data_yumi_o !== 1'b0)
            $display("FAIL wr_data_in_ready got=%b exp=0", mem_cmd_data_yumi_o);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            mem_cmd_header_v_i = 1'b0;
            mem_cmd_data_i     = 64'(17 * (k + 1));
            #1;
            checks++;
            if (mem_cmd_data_yumi_o !== 1'b1)
                $display("FAIL wr_beat%0d_yumi got=%b exp=1", k, mem_cmd_data_yumi_o);
            else passed++;
            checks++;
            if (mem_resp_header_v_o !== 1'b0)
                $display("FAIL wr_beat%0d_early_resp got=%b exp=0", k, mem_resp_header_v_o);
            else passed++;
        end
        @(negedge clk_i);
        mem_cmd_data_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1)
            $display("FAIL wr_resp_v got=%b exp=1", mem_resp_header_v_o);
        else passed++;
        checks++;
        if (mem_resp_header_o !== exp_h)
            $display("FAIL wr_resp_hdr got=%h exp=%h", mem_resp_header_o, exp_h);
        else passed++;
        @(negedge clk_i); #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b0)
            $display("FAIL wr_resp_drop got=%b exp=0", mem_resp_header_v_o);
        else passed++;
    endtask

    task automatic test_read64();
        logic [HW-1:0] exp_h;
        exp_h = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80_0000_40);
        @(negedge clk_i);
        mem_cmd_header_i   = exp_h;
        mem_cmd_header_v_i = 1'b1;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1)
            $display("FAIL rd_hdr_yumi got=%b exp=1", mem_cmd_header_yumi_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1 || mem_resp_header_o !== exp_h)
            $display("FAIL rd_resp_hdr got=%b/%h exp=1/%h",
                     mem_resp_header_v_o, mem_resp_header_o, exp_h);
        else passed++;
        checks++;
        if (mem_resp_data_v_o !== 1'b0)
            $display("FAIL rd_data_early got=%b exp=0", mem_resp_data_v_o);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i); #1;
            checks++;
            if (mem_resp_data_v_o !== 1'b1 || mem_resp_data_o !== 64'(17 * (k + 1)))
                $display("FAIL rd_beat%0d got=%b/%h exp=1/%h", k,
                         mem_resp_data_v_o, mem_resp_data_o, 64'(17 * (k + 1)));
            else passed++;
        end
        @(negedge clk_i); #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b0)
            $display("FAIL rd_extra_beat got=%b exp=0", mem_resp_data_v_o);
        else passed++;
    endtask

    task automatic test_read_backpressure();
        logic [3:0] pat;
        int got;
        pat = 4'b1001;
        got = 0;
        @(negedge clk_i);
        mem_cmd_header_i   = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80_0000_40);
        mem_cmd_header_v_i = 1'b1;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            @(negedge clk_i);
            mem_resp_data_ready_i = pat[i%4];
            #1;
            checks++;
            if (mem_resp_data_v_o !== 1'b1 || mem_resp_data_o !== 64'(17 * (got + 1)))
                $display("FAIL bp_cycle%0d got=%b/%h exp=1/%h", i,
                         mem_resp_data_v_o, mem_resp_data_o, 64'(17 * (got + 1)));
            else passed++;
            if (mem_resp_data_v_o === 1'b1 && mem_resp_data_ready_i)
                got++;
        end
        checks++;
        if (got != 8)
            $display("FAIL bp_beat_count got=%0d exp=8", got);
        else passed++;
        @(negedge clk_i);
        mem_resp_data_ready_i = 1'b1;
        #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b0)
            $display("FAIL bp_extra_beat got=%b exp=0", mem_resp_data_v_o);
        else passed++;
    endtask

    task automatic test_write_gaps();
        logic [HW-1:0] exp_h;
        int sent;
        sent  = 0;
        exp_h = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_64, 40'h80_0001_00);
        @(negedge clk_i);
        mem_cmd_header_i   = exp_h;
        mem_cmd_header_v_i = 1'b1;
        mem_cmd_data_v_i   = 1'b0;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1)
            $display("FAIL gap_hdr_yumi got=%b exp=1", mem_cmd_header_yumi_o);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            mem_cmd_header_v_i = 1'b0;
            #1;
            checks++;
            if (mem_cmd_data_yumi_o !== 1'b0 || mem_resp_header_v_o !== 1'b0)
                $display("FAIL gap_idle%0d got=%b/%b exp=0/0", i,
                         mem_cmd_data_yumi_o, mem_resp_header_v_o);
            else passed++;
        end
        for (int i = 0; i < 20 && sent < 8; i++) begin
            @(negedge clk_i);
            mem_cmd_data_v_i = (i % 2 == 0);
            mem_cmd_data_i   = 64'hA0 + 64'(sent);
            #1;
            checks++;
            if (mem_cmd_data_yumi_o !== mem_cmd_data_v_i || mem_resp_header_v_o !== 1'b0)
                $display("FAIL gap_cycle%0d got=%b/%b exp=%b/0", i,
                         mem_cmd_data_yumi_o, mem_resp_header_v_o, mem_cmd_data_v_i);
            else passed++;
            if (mem_cmd_data_v_i)
                sent++;
        end
        @(negedge clk_i);
        mem_cmd_data_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1 || mem_resp_header_o !== exp_h)
            $display("FAIL gap_resp got=%b/%h exp=1/%h",
                     mem_resp_header_v_o, mem_resp_header_o, exp_h);
        else passed++;
    endtask

    task automatic test_other_msg_b2b();
        logic [HW-1:0] h1, h2;
        h1 = mk_hdr(e_bedrock_mem_pre, e_bedrock_msg_size_64, 40'h80_0002_00);
        h2 = mk_hdr(e_bedrock_mem_pre, e_bedrock_msg_size_8, 40'h80_0003_08);
        @(negedge clk_i);
        mem_cmd_header_i        = h1;
        mem_cmd_header_v_i      = 1'b1;
        mem_cmd_data_v_i        = 1'b1;
        mem_resp_header_ready_i = 1'b0;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1)
            $display("FAIL pre_hdr_yumi got=%b exp=1", mem_cmd_header_yumi_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1 || mem_cmd_data_yumi_o !== 1'b0
            || mem_resp_data_v_o !== 1'b0)
            $display("FAIL pre_resp got=%b/%b/%b exp=1/0/0", mem_resp_header_v_o,
                     mem_cmd_data_yumi_o, mem_resp_data_v_o);
        else passed++;
        @(negedge clk_i);
        mem_resp_header_ready_i = 1'b1;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1 || mem_resp_header_o !== h1)
            $display("FAIL pre_resp_held got=%b/%h exp=1/%h",
                     mem_resp_header_v_o, mem_resp_header_o, h1);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_i   = h2;
        mem_cmd_header_v_i = 1'b1;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1 || mem_cmd_data_yumi_o !== 1'b0)
            $display("FAIL b2b_accept got=%b/%b exp=1/0",
                     mem_cmd_header_yumi_o, mem_cmd_data_yumi_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        mem_cmd_data_v_i   = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1 || mem_resp_header_o !== h2)
            $display("FAIL b2b_resp got=%b/%h exp=1/%h",
                     mem_resp_header_v_o, mem_resp_header_o, h2);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [63:0] x;
        logic [HW-1:0] rh;
        x  = 64'hDEAD_BEEF_0123_4567;
        rh = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_8, 40'h7FF8);
        @(negedge clk_i);
        mem_cmd_header_i   = mk_hdr(e_bedrock_mem_wr, e_bedrock_msg_size_8, 40'h1_FFF8);
        mem_cmd_header_v_i = 1'b1;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1)
            $display("FAIL wrap_wr_yumi got=%b exp=1", mem_cmd_header_yumi_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        mem_cmd_data_i     = x;
        mem_cmd_data_v_i   = 1'b1;
        #1;
        checks++;
        if (mem_cmd_data_yumi_o !== 1'b1)
            $display("FAIL wrap_data_yumi got=%b exp=1", mem_cmd_data_yumi_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_data_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1)
            $display("FAIL wrap_wr_resp got=%b exp=1", mem_resp_header_v_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_i   = rh;
        mem_cmd_header_v_i = 1'b1;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1 || mem_resp_header_o !== rh)
            $display("FAIL wrap_rd_hdr got=%b/%h exp=1/%h",
                     mem_resp_header_v_o, mem_resp_header_o, rh);
        else passed++;
        @(negedge clk_i); #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b1 || mem_resp_data_o !== x)
            $display("FAIL wrap_rd_data got=%b/%h exp=1/%h",
                     mem_resp_data_v_o, mem_resp_data_o, x);
        else passed++;
        @(negedge clk_i); #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b0)
            $display("FAIL wrap_extra got=%b exp=0", mem_resp_data_v_o);
        else passed++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        mem_cmd_header_i   = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80_0000_40);
        mem_cmd_header_v_i = 1'b1;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        for (int k = 0; k < 4; k++)
            @(negedge clk_i);
        #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b1 || mem_resp_data_o !== 64'h44)
            $display("FAIL rstmid_beat3 got=%b/%h exp=1/44",
                     mem_resp_data_v_o, mem_resp_data_o);
        else passed++;
        mem_cmd_header_i   = mk_hdr(e_bedrock_mem_rd, e_bedrock_msg_size_64, 40'h80_0001_00);
        mem_cmd_header_v_i = 1'b1;
        reset_i            = 1'b1;
        #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b0 || mem_resp_header_v_o !== 1'b0
            || mem_cmd_header_yumi_o !== 1'b0)
            $display("FAIL rstmid_outputs got=%b/%b/%b exp=0/0/0", mem_resp_data_v_o,
                     mem_resp_header_v_o, mem_cmd_header_yumi_o);
        else passed++;
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        checks++;
        if (mem_cmd_header_yumi_o !== 1'b1)
            $display("FAIL rstmid_accept got=%b exp=1", mem_cmd_header_yumi_o);
        else passed++;
        @(negedge clk_i);
        mem_cmd_header_v_i = 1'b0;
        #1;
        checks++;
        if (mem_resp_header_v_o !== 1'b1)
            $display("FAIL rstmid_resp_hdr got=%b exp=1", mem_resp_header_v_o);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i); #1;
            checks++;
            if (mem_resp_data_v_o !== 1'b1 || mem_resp_data_o !== 64'hA0 + 64'(k))
                $display("FAIL rstmid_beat%0d got=%b/%h exp=1/%h", k,
                         mem_resp_data_v_o, mem_resp_data_o, 64'hA0 + 64'(k));
            else passed++;
        end
        @(negedge clk_i); #1;
        checks++;
        if (mem_resp_data_v_o !== 1'b0)
            $display("FAIL rstmid_extra got=%b exp=0", mem_resp_data_v_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write64();
        test_read64();
        test_read_backpressure();
        test_write_gaps();
        test_other_msg_b2b();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
